urv_shifter_pipe: RTL and testbench
===================================

Name: urv_shifter_pipe

Overview:
- Parametrised two-stage barrel shifter for the uRV execute/writeback path.
- Generalises the fixed 32-bit shifter in three ways: configurable data width, a configurable split of shift-amount bits between stages, and rotate modes (ROL/ROR).
- Adds explicit valid tracking and a kill input, so writeback can qualify results without external bookkeeping.
- Sits beside the ALU: operands enter in execute (stage 1), the result is read in writeback (stage 2).

Parameters:
- G_XLEN, 32: data width; legal values 32 or 64.
- G_S1_BITS, 2: number of most-significant shift-amount bits resolved in stage 1; range 1 .. clog2(G_XLEN)-1. The remaining low bits are resolved in stage 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- x_stall_i  in  1  freezes the stage-1/stage-2 pipe register.
- x_kill_i  in  1  squashes the op currently captured in the pipe register.
- d_valid_i  in  1  operands valid this cycle.
- d_rs1_i  in  G_XLEN  data to shift.
- d_shamt_i  in  clog2(G_XLEN)  shift amount, unsigned.
- d_mode_i  in  3  operation: SLL, SRL, SRA, ROL, ROR (encodings in the shared defines).
- w_valid_o  out  1  result valid.
- w_rd_o  out  G_XLEN  result.

Behaviour:
- Stage 1 (combinational from d_*_i):
  - Normalise direction: reverse bit order for SLL and ROL, so every op becomes a right shift/rotate.
  - Apply the upper G_S1_BITS of shamt.
  - Fill bits: extend_sign = d_rs1_i[G_XLEN-1] for SRA, 0 for SLL/SRL; rotate modes re-inject the bits shifted out.
- Pipe register (captures stage-1 data, remaining shamt bits, mode, fill bit, valid):
  - Updates only when x_stall_i=0.
  - Valid register captures d_valid_i on update.
  - x_kill_i=1 clears the valid register on that edge, overriding both stall and d_valid_i. Data registers follow the normal stall rule.
- Stage 2 (combinational from the pipe register):
  - Apply the low shamt bits with the registered fill or rotate.
  - Un-reverse the result for SLL/ROL.
  - Drive w_rd_o and w_valid_o from the stage-2 logic and valid register; no extra output register.
- Latency: an op presented with d_valid_i in cycle N appears on w_valid_o/w_rd_o in cycle N+1, provided cycle N is unstalled. While stalled, the outputs hold steady.
- Reset (synchronous): clears all pipe registers, including data. Therefore w_valid_o=0 and w_rd_o=0 from the first cycle after reset. A reset mid-operation discards the in-flight op.
- Arithmetic rules:
  - shamt=0: w_rd_o = d_rs1_i for every mode.
  - SRA with shamt=G_XLEN-1: result is all sign bits.
  - Rotate is modulo G_XLEN; no bits are lost.
- Reserved d_mode_i encodings: w_rd_o=0; w_valid_o still follows d_valid_i (decode is responsible for never issuing them).
- Independence: d_rs1_i/d_shamt_i/d_mode_i are sampled regardless of d_valid_i. w_rd_o is don't-care when w_valid_o=0, except after reset, when it is 0.
- Simultaneous events: stall+kill → valid cleared, data held. Reset overrides everything.

Decomposition:
- Shared defines header (alongside the existing FUNC_* defines):
  - SHIFT_MODE_SLL=3'b000, SHIFT_MODE_SRL=3'b001, SHIFT_MODE_SRA=3'b010, SHIFT_MODE_ROL=3'b011, SHIFT_MODE_ROR=3'b100.
  - A function/macro for G_XLEN-wide bit reversal.
- Sub-module urv_shifter_rstage: parametrised combinational right-shift/rotate over a contiguous range of shamt bits, with a fill input and a rotate flag. It is instantiated once per stage.

Test Plan:
1. G_XLEN=32: SRA, rs1=0x8000_0000, shamt=31 → cycle N+1: w_valid_o=1, w_rd_o=0xFFFF_FFFF. Same with SRL → 0x0000_0001.
2. SLL 0x0000_0001 shamt=31 → 0x8000_0000. ROL 0x8000_0001 shamt=4 → 0x0000_0018. ROR 0x0000_0001 shamt=1 → 0x8000_0000. All modes with shamt=0 return rs1 unchanged.
3. Hold stall for 3 cycles after issuing ROR 0x1234_5678 shamt=8 while changing d_rs1_i → output held. After release: w_rd_o=0x7812_3456, then the new op follows.
4. Kill with stall asserted in the same cycle as a valid op is in the register → next cycle w_valid_o=0. A back-to-back valid op afterwards completes normally.
5. Reset asserted with a valid op in flight → next cycle w_valid_o=0, w_rd_o=0. The first op after deassert has latency 1.
6. G_XLEN=64, G_S1_BITS=3: SRA 0x8000_0000_0000_0000 shamt=63 → all ones. ROL 0x1 shamt=63 → 0x8000_0000_0000_0000. Random sweep against a reference model for every mode and every shamt.

Source files
------------

// File: rtl/urv_shifter_pipe_pkg.sv
// Shared definitions for the uRV two-stage shifter: shift mode encodings
// and an XLEN-wide bit reversal helper.
package urv_shifter_pipe_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    SHIFT_MODE_SLL = 3'b000,
    SHIFT_MODE_SRL = 3'b001,
    SHIFT_MODE_SRA = 3'b010,
    SHIFT_MODE_ROL = 3'b011,
    SHIFT_MODE_ROR = 3'b100
  } shift_mode_e;

  // Reverses the low xlen bits of v; the result sits in the low xlen bits.
  function automatic logic [MAX_XLEN-1:0] bit_rev(input logic [MAX_XLEN-1:0] v,
                                                  input int unsigned xlen);
    logic [MAX_XLEN-1:0] r;
    r = {<<{v}};
    return r >> (MAX_XLEN - xlen);
  endfunction

endpackage

// File: rtl/urv_shifter_pipe_if.sv
// Operand/result bundle between execute, the shifter and writeback.
interface urv_shifter_pipe_if #(
  parameter int G_XLEN = 32
) ();
  localparam int SHW = $clog2(G_XLEN);

  // Valid-only flow: no ready. Operands are sampled every unstalled cycle
  // whether or not d_valid_i is set; w_valid_o qualifies w_rd_o one cycle later.
  logic              d_valid_i;
  logic [G_XLEN-1:0] d_rs1_i;
  logic [SHW-1:0]    d_shamt_i;
  logic [2:0]        d_mode_i;
  logic              w_valid_o;
  logic [G_XLEN-1:0] w_rd_o;

  modport master (
    output d_valid_i, d_rs1_i, d_shamt_i, d_mode_i,
    input  w_valid_o, w_rd_o
  );

  modport slave (
    input  d_valid_i, d_rs1_i, d_shamt_i, d_mode_i,
    output w_valid_o, w_rd_o
  );
endinterface

// File: rtl/urv_shifter_rstage.sv
// Combinational right shift/rotate over a contiguous slice of shift-amount
// bits starting at bit position G_LO.
module urv_shifter_rstage #(
  parameter int G_XLEN  = 32,
  parameter int G_LO    = 0,
  parameter int G_NBITS = 2
) (
  input  logic [G_XLEN-1:0]  data_i,
  input  logic [G_NBITS-1:0] shamt_i,
  input  logic               fill_i,
  input  logic               rotate_i,
  output logic [G_XLEN-1:0]  data_o
);

  localparam logic [G_XLEN-1:0] C_ONES = {G_XLEN{1'b1}};

  logic [G_XLEN-1:0] acc;
  int unsigned       amt;

  always_comb begin
    acc = data_i;
    amt = 0;
    for (int k = 0; k < G_NBITS; k++) begin
      amt = 32'd1 << (G_LO + k);
      if (shamt_i[k]) begin
        if (rotate_i) begin
          acc = (acc >> amt) | (acc << (G_XLEN - amt));
        end else begin
          acc = (acc >> amt) | (fill_i ? ~(C_ONES >> amt) : '0);
        end
      end
    end
    data_o = acc;
  end

endmodule

// File: rtl/urv_shifter_pipe.sv
// Two-stage barrel shifter: upper shift-amount bits in execute, the rest in
// writeback. Left ops are bit-reversed so both stages only shift right.
module urv_shifter_pipe
  import urv_shifter_pipe_pkg::*;
#(
  parameter int G_XLEN    = 32,
  parameter int G_S1_BITS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    x_stall_i,
  input  logic                    x_kill_i,
  urv_shifter_pipe_if.slave       bus
);

  localparam int SHW     = $clog2(G_XLEN);
  localparam int S2_BITS = SHW - G_S1_BITS;

  // Stage 1 decode and normalisation
  logic              s1_left;
  logic              s1_rot;
  logic              s1_fill;
  logic [G_XLEN-1:0] s1_norm;
  logic [G_XLEN-1:0] s1_data;

  always_comb begin
    s1_left = (bus.d_mode_i == SHIFT_MODE_SLL) || (bus.d_mode_i == SHIFT_MODE_ROL);
    s1_rot  = (bus.d_mode_i == SHIFT_MODE_ROL) || (bus.d_mode_i == SHIFT_MODE_ROR);
    s1_fill = (bus.d_mode_i == SHIFT_MODE_SRA) && bus.d_rs1_i[G_XLEN-1];
    s1_norm = s1_left ? G_XLEN'(bit_rev(MAX_XLEN'(bus.d_rs1_i), G_XLEN)) : bus.d_rs1_i;
  end

  urv_shifter_rstage #(
    .G_XLEN  (G_XLEN),
    .G_LO    (S2_BITS),
    .G_NBITS (G_S1_BITS)
  ) u_stage1 (
    .data_i   (s1_norm),
    .shamt_i  (bus.d_shamt_i[SHW-1 -: G_S1_BITS]),
    .fill_i   (s1_fill),
    .rotate_i (s1_rot),
    .data_o   (s1_data)
  );

  // Pipe register between execute and writeback
  logic [G_XLEN-1:0]  p_data;
  logic [S2_BITS-1:0] p_shamt;
  logic [2:0]         p_mode;
  logic               p_fill;
  logic               p_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_data  <= '0;
      p_shamt <= '0;
      p_mode  <= '0;
      p_fill  <= 1'b0;
      p_valid <= 1'b0;
    end else begin
      if (!x_stall_i) begin
        p_data  <= s1_data;
        p_shamt <= bus.d_shamt_i[S2_BITS-1:0];
        p_mode  <= bus.d_mode_i;
        p_fill  <= s1_fill;
        p_valid <= bus.d_valid_i;
      end
      // Kill drops the op even while stalled; the data stays put.
      if (x_kill_i) begin
        p_valid <= 1'b0;
      end
    end
  end

  // Stage 2: finish the shift, undo the reversal, zero reserved modes
  logic              s2_left;
  logic              s2_rot;
  logic              s2_legal;
  logic [G_XLEN-1:0] s2_data;
  logic [G_XLEN-1:0] s2_res;

  urv_shifter_rstage #(
    .G_XLEN  (G_XLEN),
    .G_LO    (0),
    .G_NBITS (S2_BITS)
  ) u_stage2 (
    .data_i   (p_data),
    .shamt_i  (p_shamt),
    .fill_i   (p_fill),
    .rotate_i (s2_rot),
    .data_o   (s2_data)
  );

  always_comb begin
    s2_left  = (p_mode == SHIFT_MODE_SLL) || (p_mode == SHIFT_MODE_ROL);
    s2_rot   = (p_mode == SHIFT_MODE_ROL) || (p_mode == SHIFT_MODE_ROR);
    s2_legal = (p_mode <= SHIFT_MODE_ROR);
    s2_res   = s2_left ? G_XLEN'(bit_rev(MAX_XLEN'(s2_data), G_XLEN)) : s2_data;
  end

  assign bus.w_rd_o    = s2_legal ? s2_res : '0;
  assign bus.w_valid_o = p_valid;

endmodule

// File: tb/tb_urv_shifter_pipe.sv
// Bench for urv_shifter_pipe: a 32-bit and a 64-bit instance driven in
// lockstep, checked against an arithmetic shift/rotate model.
module tb_urv_shifter_pipe;
  import urv_shifter_pipe_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        st_rst;
  logic        st_stall;
  logic        st_kill;
  logic        st_valid;
  logic [2:0]  st_mode;
  logic [63:0] st_rs1;
  logic [4:0]  st_sh32;
  logic [5:0]  st_sh64;

  urv_shifter_pipe_if #(.G_XLEN(32)) if32 ();
  urv_shifter_pipe_if #(.G_XLEN(64)) if64 ();

  assign if32.d_valid_i = st_valid;
  assign if32.d_rs1_i   = st_rs1[31:0];
  assign if32.d_shamt_i = st_sh32;
  assign if32.d_mode_i  = st_mode;
  assign if64.d_valid_i = st_valid;
  assign if64.d_rs1_i   = st_rs1;
  assign if64.d_shamt_i = st_sh64;
  assign if64.d_mode_i  = st_mode;

  urv_shifter_pipe #(.G_XLEN(32), .G_S1_BITS(2)) dut32 (
    .clk_i     (clk),
    .rst_i     (st_rst),
    .x_stall_i (st_stall),
    .x_kill_i  (st_kill),
    .bus       (if32)
  );

  urv_shifter_pipe #(.G_XLEN(64), .G_S1_BITS(3)) dut64 (
    .clk_i     (clk),
    .rst_i     (st_rst),
    .x_stall_i (st_stall),
    .x_kill_i  (st_kill),
    .bus       (if64)
  );

  // Scoreboard: exp_q holds the result currently expected at writeback
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q32[$];
  logic [63:0] exp_q64[$];
  logic        m_valid = 1'b0;
  logic        m_zero  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] mode, input logic [63:0] rs1,
                                         input int sh, input int xlen);
    logic [127:0] x;
    logic [127:0] mask;
    logic [127:0] r;
    logic         sign;
    mask = (128'd1 << xlen) - 128'd1;
    x    = {64'd0, rs1} & mask;
    sign = ((x >> (xlen - 1)) & 128'd1) != 128'd0;
    case (mode)
      3'd0:    r = (x << sh) & mask;
      3'd1:    r = x >> sh;
      3'd2:    r = (x >> sh) | (sign ? (mask & ~(mask >> sh)) : 128'd0);
      3'd3:    r = ((x << sh) | (x >> (xlen - sh))) & mask;
      3'd4:    r = ((x >> sh) | (x << (xlen - sh))) & mask;
      default: r = 128'd0;
    endcase
    return r[63:0];
  endfunction

  // One clock: advance the model on the edge, then compare just after it.
  task automatic step();
    logic [63:0] e32;
    logic [63:0] e64;
    @(posedge clk);
    if (st_rst) begin
      m_valid = 1'b0;
      m_zero  = 1'b1;
      exp_q32 = {32'h0};
      exp_q64 = {64'h0};
    end else begin
      if (!st_stall) begin
        e32 = ref_op(st_mode, st_rs1, int'(st_sh32), 32);
        e64 = ref_op(st_mode, st_rs1, int'(st_sh64), 64);
        void'(exp_q32.pop_front());
        void'(exp_q64.pop_front());
        exp_q32.push_back(e32[31:0]);
        exp_q64.push_back(e64);
        m_valid = st_valid;
        m_zero  = 1'b0;
      end
      if (st_kill) m_valid = 1'b0;
    end
    #1;
    check_eq("valid32", 64'(if32.w_valid_o), 64'(m_valid));
    check_eq("valid64", 64'(if64.w_valid_o), 64'(m_valid));
    if (m_valid || m_zero) begin
      check_eq("rd32", 64'(if32.w_rd_o), 64'(exp_q32[0]));
      check_eq("rd64", if64.w_rd_o, exp_q64[0]);
    end
  endtask

  // Driver
  task automatic issue(input logic [2:0] mode, input logic [63:0] rs1,
                       input int sh32, input int sh64);
    st_valid = 1'b1;
    st_mode  = mode;
    st_rs1   = rs1;
    st_sh32  = 5'(sh32);
    st_sh64  = 6'(sh64);
    st_stall = 1'b0;
    st_kill  = 1'b0;
    step();
  endtask

  initial begin
    exp_q32  = {32'h0};
    exp_q64  = {64'h0};
    st_rst   = 1'b1;
    st_stall = 1'b0;
    st_kill  = 1'b0;
    st_valid = 1'b1;
    st_mode  = SHIFT_MODE_ROR;
    st_rs1   = 64'hDEAD_BEEF_CAFE_F00D;
    st_sh32  = 5'd3;
    st_sh64  = 6'd3;
    step();
    step();
    check_eq("reset_valid", 64'(if32.w_valid_o), 64'd0);
    check_eq("reset_rd32", 64'(if32.w_rd_o), 64'd0);
    check_eq("reset_rd64", if64.w_rd_o, 64'd0);
    st_rst = 1'b0;

    // Boundary shifts
    issue(SHIFT_MODE_SRA, 64'h8000_0000_8000_0000, 31, 63);
    check_eq("sra31", 64'(if32.w_rd_o), 64'hFFFF_FFFF);
    check_eq("sra63", if64.w_rd_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("sra_valid", 64'(if32.w_valid_o), 64'd1);
    issue(SHIFT_MODE_SRL, 64'h0000_0000_8000_0000, 31, 31);
    check_eq("srl31", 64'(if32.w_rd_o), 64'h1);
    issue(SHIFT_MODE_SLL, 64'h1, 31, 1);
    check_eq("sll31", 64'(if32.w_rd_o), 64'h8000_0000);
    issue(SHIFT_MODE_ROL, 64'h1, 31, 63);
    check_eq("rol63", if64.w_rd_o, 64'h8000_0000_0000_0000);
    issue(SHIFT_MODE_ROL, 64'h8000_0001, 4, 4);
    check_eq("rol4", 64'(if32.w_rd_o), 64'h18);
    issue(SHIFT_MODE_ROR, 64'h1, 1, 1);
    check_eq("ror1", 64'(if32.w_rd_o), 64'h8000_0000);
    for (int m = 0; m < 5; m++) begin
      issue(3'(m), {$urandom(), $urandom()}, 0, 0);
      check_eq("sh0_32", 64'(if32.w_rd_o), 64'(st_rs1[31:0]));
      check_eq("sh0_64", if64.w_rd_o, st_rs1);
    end
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 5, 5);
    check_eq("reserved_rd", 64'(if32.w_rd_o), 64'd0);
    check_eq("reserved_valid", 64'(if32.w_valid_o), 64'd1);

    // Stall holds the result while the operands keep moving
    issue(SHIFT_MODE_ROR, 64'h1234_5678, 8, 8);
    check_eq("ror8", 64'(if32.w_rd_o), 64'h7812_3456);
    st_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_rs1 = {$urandom(), $urandom()};
      step();
      check_eq("stall_hold", 64'(if32.w_rd_o), 64'h7812_3456);
    end
    st_stall = 1'b0;
    st_mode  = SHIFT_MODE_SRL;
    step();

    // Kill together with stall
    issue(SHIFT_MODE_SLL, 64'h3, 2, 2);
    st_stall = 1'b1;
    st_kill  = 1'b1;
    step();
    check_eq("kill_valid", 64'(if32.w_valid_o), 64'd0);
    issue(SHIFT_MODE_SRA, 64'hF000_0000_F000_0000, 4, 4);
    check_eq("after_kill", 64'(if32.w_rd_o), 64'hFF00_0000);

    // Reset mid-flight
    issue(SHIFT_MODE_ROL, 64'hABCD_0123, 7, 9);
    st_rst = 1'b1;
    step();
    check_eq("midrst_valid", 64'(if64.w_valid_o), 64'd0);
    check_eq("midrst_rd32", 64'(if32.w_rd_o), 64'd0);
    check_eq("midrst_rd64", if64.w_rd_o, 64'd0);
    st_rst = 1'b0;
    issue(SHIFT_MODE_SRL, 64'hF0, 4, 4);
    check_eq("post_rst32", 64'(if32.w_rd_o), 64'hF);
    check_eq("post_rst64", if64.w_rd_o, 64'hF);

    // Sweep every mode and shift amount with random stall/kill/valid
    for (int m = 0; m < 8; m++) begin
      for (int s = 0; s < 64; s++) begin
        st_mode  = 3'(m);
        st_rs1   = {$urandom(), $urandom()};
        st_sh64  = 6'(s);
        st_sh32  = 5'(s);
        st_valid = ($urandom_range(0, 7) != 0);
        st_stall = ($urandom_range(0, 7) == 0);
        st_kill  = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    for (int i = 0; i < 300; i++) begin
      st_mode  = 3'($urandom_range(0, 4));
      st_rs1   = {$urandom(), $urandom()};
      st_sh64  = 6'($urandom_range(0, 63));
      st_sh32  = 5'($urandom_range(0, 31));
      st_valid = ($urandom_range(0, 3) != 0);
      st_stall = ($urandom_range(0, 5) == 0);
      st_kill  = ($urandom_range(0, 11) == 0);
      st_rst   = ($urandom_range(0, 63) == 0);
      step();
    end
    st_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
